// File: rtl/conv_pkg.sv
// Shared constants for the convolution normalisation datapath.
package conv_pkg;

  // Divider FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Default operand widths
  localparam int unsigned CONV_DW = 8;
  localparam int unsigned CONV_VW = 4;

endpackage

// File: rtl/ripple_subtractor.sv
// Ripple-carry subtractor: a - b as a + ~b + 1 on a full-adder chain.
module ripple_subtractor #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0]   c;
  logic [W-1:0] bn;

  assign bn   = ~b;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i] = a[i] ^ bn[i] ^ c[i];
    assign c[i+1]  = (a[i] & bn[i]) | (c[i] & (a[i] ^ bn[i]));
  end

  // No carry out of a + ~b + 1 means b > a
  assign borrow = ~c[W];

endmodule

// File: rtl/conv_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module conv_restoring_divider
  import conv_pkg::*;
#(
  parameter int unsigned DW = CONV_DW,
  parameter int unsigned VW = CONV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned PW = VW + 1;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] d_q, d_d;
  logic [VW-1:0] v_q, v_d;
  logic [PW-1:0] p_q, p_d;
  logic [DW-1:0] qsh_q, qsh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  logic [PW-1:0] t;
  logic [PW-1:0] s;
  logic          borrow;
  logic          last;
  logic [DW-1:0] qsh_next;
  logic [PW-1:0] p_next;

  // Shift the next dividend bit into the partial remainder; P < V keeps P[VW] zero
  assign t = {p_q[VW-1:0], d_q[DW-1]};

  ripple_subtractor #(
    .W(PW)
  ) u_sub (
    .a     (t),
    .b     ({1'b0, v_q}),
    .diff  (s),
    .borrow(borrow)
  );

  assign last     = (cnt_q == CW'(DW - 1));
  assign qsh_next = {qsh_q[DW-2:0], ~borrow};
  assign p_next   = borrow ? t : s;

  // Next-state logic: accept in IDLE/DONE, iterate in RUN
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    p_d     = p_q;
    qsh_d   = qsh_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          d_d     = dividend;
          v_d     = divisor;
          p_d     = '0;
          qsh_d   = '0;
          cnt_d   = '0;
          dbz_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        d_d   = {d_q[DW-2:0], 1'b0};
        p_d   = p_next;
        qsh_d = qsh_next;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (v_q == '0) begin
            quo_d = '1;
            rem_d = '0;
            dbz_d = 1'b1;
          end else begin
            quo_d = qsh_next;
            rem_d = p_next[VW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      v_q     <= '0;
      p_q     <= '0;
      qsh_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      p_q     <= p_d;
      qsh_q   <= qsh_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_conv_restoring_divider.sv
// Self-checking bench for conv_restoring_divider (DW=8, VW=4).
module tb_conv_restoring_divider;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int errors = 0;

  conv_restoring_divider #(
    .DW(DW),
    .VW(VW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero rule
  function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                output logic [DW-1:0] q, output logic [VW-1:0] r,
                                output logic z);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (ib == 0) begin
      q = '1;
      r = '0;
      z = 1'b1;
    end else begin
      q = DW'(ia / ib);
      r = VW'(ia % ib);
      z = 1'b0;
    end
  endfunction

  // One division; returns results sampled in the done cycle and edges from accept to done
  task automatic do_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        output logic [DW-1:0] q, output logic [VW-1:0] r,
                        output logic z, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      // A start during RUN must be ignored
      if (lat == 3) start = 1'b1;
      if (lat == 4) start = 1'b0;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  logic [DW-1:0] gq, eq, na;
  logic [VW-1:0] gr, er, nb;
  logic          gz, ez;
  int            lat, cyc, ndone;
  int            order[4096];

  initial begin
    vecs[0] = '{a: 8'd200, b: 4'd9,  q: 8'd22,  r: 4'd2, z: 1'b0};
    vecs[1] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0, z: 1'b0};
    vecs[2] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, z: 1'b0};
    vecs[3] = '{a: 8'd5,   b: 4'd7,  q: 8'd0,   r: 4'd5, z: 1'b0};
    vecs[4] = '{a: 8'd100, b: 4'd0,  q: 8'd255, r: 4'd0, z: 1'b1};
    vecs[5] = '{a: 8'd8,   b: 4'd2,  q: 8'd4,   r: 4'd0, z: 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_outputs", {busy, done, quotient, remainder, div_by_zero}, 32'd0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      do_div(vecs[i].a, vecs[i].b, gq, gr, gz, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(DW));
      chk($sformatf("vec%0d_quotient", i), 32'(gq), 32'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), 32'(gr), 32'(vecs[i].r));
      chk($sformatf("vec%0d_dbz", i), 32'(gz), 32'(vecs[i].z));
      chk($sformatf("vec%0d_busy_in_done", i), 32'(busy), 32'd0);
    end

    // Back-to-back with start held high
    @(negedge clk);
    na = DW'($urandom);
    nb = VW'($urandom);
    dividend = na;
    divisor  = nb;
    start    = 1'b1;
    @(posedge clk);
    model(na, nb, eq, er, ez);
    #1;
    chk("b2b_busy_after_accept", 32'(busy), 32'd1);
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    for (int k = 0; k < 6; k++) begin
      cyc = 0;
      do begin
        @(posedge clk);
        #1;
        cyc++;
      end while (!done && cyc < 40);
      chk($sformatf("b2b%0d_latency", k), 32'(cyc), 32'(DW));
      chk($sformatf("b2b%0d_result", k), {quotient, remainder, div_by_zero},
          {eq, er, ez});
      if (k < 5) begin
        na = DW'($urandom);
        nb = VW'($urandom);
        dividend = na;
        divisor  = nb;
        @(posedge clk);
        model(na, nb, eq, er, ez);
        #1;
        chk($sformatf("b2b%0d_reaccept", k), {busy, done}, 32'b10);
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
      end else begin
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_end_idle", {busy, done}, 32'b00);
      end
    end

    // Reset in the middle of 200 / 9
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {busy, done, quotient, remainder, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    do_div(8'd50, 4'd7, gq, gr, gz, lat);
    chk("post_rst_latency", 32'(lat), 32'(DW));
    chk("post_rst_result", {gq, gr, gz}, {8'd7, 4'd1, 1'b0});

    // Full operand sweep in shuffled order
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j, tmp;
      j = int'($urandom_range(i, 0));
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 4096; i++) begin
      na = DW'(order[i] >> 4);
      nb = VW'(order[i] & 15);
      model(na, nb, eq, er, ez);
      do_div(na, nb, gq, gr, gz, lat);
      chk($sformatf("sweep_%0d_div_%0d", na, nb), {8'(lat), gq, gr, gz},
          {8'(DW), eq, er, ez});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
